// File: rtl/tmcu_gpio_pkg.sv
// Shared types for the T-MCU GPIO access controller: register map, FSM states, default width.
package tmcu_gpio_pkg;

  localparam int GPIO_W = 32;

  typedef enum logic [1:0] {
    ADDR_OUT      = 2'd0,
    ADDR_IN       = 2'd1,
    ADDR_IRQ_EN   = 2'd2,
    ADDR_IRQ_PEND = 2'd3
  } gpio_addr_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/tmcu_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered pointer.
// The pointer moves to one past the winner whenever update_en is high.
module tmcu_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   idx;
  logic          found;

  // Scan starting at ptr_q and wrapping modulo N; the first asserted request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) ptr_nxt = (i == N-1) ? '0 : PW'(i+1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            ptr_q <= '0;
    else if (update_en) ptr_q <= ptr_nxt;
  end

endmodule

// File: rtl/tmcu_gpio_ctrl.sv
// Multi-requester GPIO register controller: round-robin access to OUT / IN / IRQ_EN / IRQ_PEND.
// Edge interrupts exist only when TMCU_GPIO_CTRL_IRQ_EN is defined; otherwise addr 2/3 read 0.
module tmcu_gpio_ctrl
  import tmcu_gpio_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int W    = GPIO_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ-1:0][1:0]     req_addr,
  input  logic [NREQ-1:0][W-1:0]   req_mask,
  input  logic [NREQ-1:0][W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [W-1:0]             rsp_rdata,
  input  logic [W-1:0]             gpio_in,
  output logic [W-1:0]             gpio_out,
  output logic                     irq,
  output ctrl_state_e              state_dbg
);

  // Handshake: a requester holds valid and payload stable; the access completes on the
  // edge where valid & ready are both high, and its response strobes one cycle later.

  ctrl_state_e     state_q, state_nxt;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] gnt_q;
  logic            hs;

  logic            sel_write;
  logic [1:0]      sel_addr_raw;
  gpio_addr_e      sel_addr;
  logic [W-1:0]    sel_mask;
  logic [W-1:0]    sel_wdata;

  logic [W-1:0]    sync1_q, sync2_q;
  logic [W-1:0]    out_q;
  logic [W-1:0]    rdata_q;
  logic [W-1:0]    rd_val;
  logic [W-1:0]    en_val, pend_val;

  tmcu_rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .update_en (hs),
    .grant     (grant)
  );

  assign hs        = (state_q == IDLE) && !rst && (|req_valid);
  assign gpio_out  = out_q;
  assign state_dbg = state_q;

  // Grant is one-hot, so OR-reduction selects the winner's payload.
  always_comb begin
    sel_write    = 1'b0;
    sel_addr_raw = 2'b00;
    sel_mask     = '0;
    sel_wdata    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_write    = sel_write    | req_write[i];
        sel_addr_raw = sel_addr_raw | req_addr[i];
        sel_mask     = sel_mask     | req_mask[i];
        sel_wdata    = sel_wdata    | req_wdata[i];
      end
    end
  end
  assign sel_addr = gpio_addr_e'(sel_addr_raw);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are masked by rst so a response caught by reset is never presented.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!rst) begin
      case (state_q)
        IDLE: req_ready = grant;
        RESP: begin
          rsp_valid = gnt_q;
          rsp_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel_addr)
      ADDR_OUT:      rd_val = out_q;
      ADDR_IN:       rd_val = sync2_q;
      ADDR_IRQ_EN:   rd_val = en_val;
      ADDR_IRQ_PEND: rd_val = pend_val;
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (hs) begin
        gnt_q   <= grant;
        rdata_q <= rd_val;
        if (sel_write && sel_addr == ADDR_OUT)
          out_q <= (out_q & ~sel_mask) | (sel_wdata & sel_mask);
      end
    end
  end

`ifdef TMCU_GPIO_CTRL_IRQ_EN
  logic [W-1:0] sync_d_q, en_q, pend_q;
  logic [W-1:0] rise, en_nxt, pend_clr, pend_nxt;
  logic         irq_q;

  assign rise     = sync2_q & ~sync_d_q;
  assign en_nxt   = (hs && sel_write && sel_addr == ADDR_IRQ_EN)
                  ? ((en_q & ~sel_mask) | (sel_wdata & sel_mask)) : en_q;
  assign pend_clr = (hs && sel_write && sel_addr == ADDR_IRQ_PEND)
                  ? (sel_mask & sel_wdata) : '0;
  // Clear first, then set: a fresh edge in the clearing cycle is not lost.
  assign pend_nxt = (pend_q & ~pend_clr) | (rise & en_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d_q <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_d_q <= sync2_q;
      en_q     <= en_nxt;
      pend_q   <= pend_nxt;
      irq_q    <= |(pend_nxt & en_nxt);
    end
  end

  assign en_val   = en_q;
  assign pend_val = pend_q;
  assign irq      = irq_q;
`else
  assign en_val   = '0;
  assign pend_val = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_tmcu_gpio_ctrl.sv
// Directed bench for tmcu_gpio_ctrl: driver tasks push expected responses, a monitor pops them.
// Edge-interrupt vectors run when TMCU_GPIO_CTRL_IRQ_EN is defined.
module tb_tmcu_gpio_ctrl;
  import tmcu_gpio_pkg::*;

  localparam int NREQ = 3;
  localparam int W    = 32;
  localparam int EW   = NREQ + W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ-1:0][1:0]   req_addr;
  logic [NREQ-1:0][W-1:0] req_mask;
  logic [NREQ-1:0][W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [W-1:0]           rsp_rdata;
  logic [W-1:0]           gpio_in;
  logic [W-1:0]           gpio_out;
  logic                   irq;
  ctrl_state_e            state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  tmcu_gpio_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_mask  (req_mask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'({rsp_valid, rsp_rdata}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp", 64'({rsp_valid, rsp_rdata}), 64'(e));
      end
    end else begin
      check("rdata_idle_zero", 64'(rsp_rdata), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input int r, input logic wr, input logic [1:0] a,
                           input logic [W-1:0] m, input logic [W-1:0] d,
                           input logic [W-1:0] exp_rdata);
    logic [NREQ-1:0] oh;
    int   waited;
    logic got;
    oh = '0;
    oh[r] = 1'b1;
    exp_q.push_back({oh, exp_rdata});
    req_write[r] = wr;
    req_addr[r]  = a;
    req_mask[r]  = m;
    req_wdata[r] = d;
    req_valid[r] = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      if (req_ready[r]) got = 1'b1;
    end
    check("grant_seen", 64'(got), 64'd1);
    if (!got) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NREQ-1:0] exp_oh;
    logic [NREQ-1:0] oh;
    int waited;
    logic got;

    rst       = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_mask  = '0;
    req_wdata = '0;
    gpio_in   = '0;

    // Reset: requests present but nothing may be granted or returned.
    wait_cycles(3);
    @(negedge clk);
    check("rst_gpio_out", 64'(gpio_out), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention: all three read OUT (=0); pointer starts at 0 so order is 0,1,2,0,1,2.
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      exp_oh = '0;
      exp_oh[k % NREQ] = 1'b1;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 10) begin
        @(negedge clk);
        waited++;
        if (req_ready != '0) got = 1'b1;
      end
      check("rr_grant", 64'(req_ready), 64'(exp_oh));
      if (k > 0) check("rr_spacing", 64'(waited), 64'd2);
      if (got) exp_q.push_back({exp_oh, {W{1'b0}}});
      @(posedge clk);
      #1;
      if (k == 5) req_valid = '0;
    end
    wait_cycles(2);

    // OUT masked writes and reads.
    do_access(0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_0000);
    check("out_full_write", 64'(gpio_out), 64'hFFFF_0000);
    do_access(0, 1'b1, 2'd0, 32'h0000_FFFF, 32'hA5A5_A5A5, 32'hFFFF_0000);
    check("out_masked_write", 64'(gpio_out), 64'hFFFF_A5A5);
    do_access(1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_A5A5);
    check("out_after_read", 64'(gpio_out), 64'hFFFF_A5A5);
    do_access(2, 1'b1, 2'd0, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_A5A5);
    check("out_zero_mask", 64'(gpio_out), 64'hFFFF_A5A5);
    do_access(2, 1'b1, 2'd0, 32'hF0F0_0000, 32'h0F0F_0000, 32'hFFFF_A5A5);
    check("out_clear_bits", 64'(gpio_out), 64'h0F0F_A5A5);

    // IN path through the synchroniser; writes to IN are ignored.
    gpio_in = 32'h1234_5678;
    wait_cycles(3);
    do_access(1, 1'b0, 2'd1, 32'h0, 32'h0, 32'h1234_5678);
    do_access(0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678);
    do_access(2, 1'b0, 2'd1, 32'h0, 32'h0, 32'h1234_5678);
    check("out_after_in_write", 64'(gpio_out), 64'h0F0F_A5A5);

    // Reset during RESP: response dropped, registers cleared, reissue completes.
    req_write[0] = 1'b1;
    req_addr[0]  = 2'd0;
    req_mask[0]  = 32'hFFFF_FFFF;
    req_wdata[0] = 32'hCAFE_F00D;
    req_valid[0] = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 10) begin
      @(negedge clk);
      waited++;
      if (req_ready[0]) got = 1'b1;
    end
    check("rstresp_grant", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstresp_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstresp_state", 64'(state_dbg), 64'(IDLE));
    check("rstresp_out_cleared", 64'(gpio_out), 64'd0);
    do_access(0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0000_0000);
    check("reissue_out", 64'(gpio_out), 64'hCAFE_F00D);
    wait_cycles(3);

`ifdef TMCU_GPIO_CTRL_IRQ_EN
    // Enable bit 0, then raise gpio_in[0]: pending and irq appear 3 cycles later.
    do_access(0, 1'b1, 2'd2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0);
    do_access(1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0000_0001);
    gpio_in = 32'h1234_5679;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("irq_not_yet", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq_set", 64'(irq), 64'd1);
    do_access(2, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    @(negedge clk);
    check("irq_cleared", 64'(irq), 64'd0);
    do_access(0, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0);

    // New edge arrives exactly on the W1C grant edge: the set wins.
    gpio_in = 32'h1234_5678;
    wait_cycles(4);
    gpio_in = 32'h1234_5679;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_access(1, 1'b1, 2'd3, 32'h0000_0001, 32'h0000_0001, 32'h0);
    @(negedge clk);
    check("set_wins_irq", 64'(irq), 64'd1);
    do_access(2, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0000_0001);
`else
    // Interrupt registers absent: reads return 0, writes vanish, irq stays low.
    do_access(0, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    do_access(1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h0);
    gpio_in = 32'h1234_5679;
    wait_cycles(4);
    do_access(2, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("irq_tied_low", 64'(irq), 64'd0);
    check("out_untouched", 64'(gpio_out), 64'hCAFE_F00D);
`endif

    wait_cycles(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
